// File: rtl/sequence_detector_pkg.sv
// Shared types and constants for the serial 0110 pattern detector.
package sequence_detector_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S01  = 3'd2,
    S011 = 3'd3,
    DET  = 3'd4
  } state_e;

  localparam logic [3:0] PATTERN     = 4'b0110;
  localparam int         PATTERN_LEN = 4;

endpackage

// File: rtl/sequence_detector.sv
// Moore FSM detecting the serial pattern 0110 (MSB first), overlapping matches allowed.
module sequence_detector
  import sequence_detector_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic detected
);

  state_e r_state;
  state_e w_next_state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // DET behaves like S0 on the next bit so the trailing 0 seeds the next match.
  always_comb begin
    w_next_state = IDLE;
    case (r_state)
      IDLE:    w_next_state = rx ? IDLE : S0;
      S0:      w_next_state = rx ? S01  : S0;
      S01:     w_next_state = rx ? S011 : S0;
      S011:    w_next_state = rx ? IDLE : DET;
      DET:     w_next_state = rx ? S01  : S0;
      default: w_next_state = IDLE;
    endcase
  end

  assign detected = (r_state == DET);

endmodule

// File: tb/tb_sequence_detector.sv
// Directed bench for sequence_detector: reset, single/overlapping matches, misses, mid-pattern reset, input timing.
module tb_sequence_detector;
  import sequence_detector_pkg::*;

  logic clk;
  logic rstn;
  logic rx;
  logic detected;

  int n_assert = 0;
  int n_fail   = 0;

  sequence_detector dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx       (rx),
    .detected (detected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive rx 1 ns after the previous edge, sample the output 1 ns after the next edge.
  task automatic step(input logic b, input logic exp, input string tag);
    rx = b;
    @(posedge clk);
    #1;
    check(tag, {2'b00, detected}, {2'b00, exp});
  endtask

  // Drive rx in the same timestep as the edge; the edge still samples the old value.
  task automatic edge_step(input logic b, input logic exp, input string tag);
    @(posedge clk);
    rx <= b;
    #1;
    check(tag, {2'b00, detected}, {2'b00, exp});
  endtask

  initial begin
    rstn = 1'b1;
    rx   = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check("reset_async_det", {2'b00, detected}, 3'd0);
    check("reset_async_state", dut.r_state, IDLE);
    for (int i = 0; i < 2; i++) begin
      rx = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("reset_hold_det", {2'b00, detected}, 3'd0);
    end
    check("reset_release_state", dut.r_state, IDLE);
    rstn = 1'b1;

    // Single match, then overlapping second match three cycles later
    step(1'b0, 1'b0, "seq_a0");
    step(1'b1, 1'b0, "seq_a1");
    step(1'b1, 1'b0, "seq_a2");
    step(1'b0, 1'b1, "seq_a3_pulse");
    step(1'b1, 1'b0, "seq_a4_pulse_end");
    step(1'b1, 1'b0, "ovl_b1");
    step(1'b0, 1'b1, "ovl_pulse2");
    step(1'b1, 1'b0, "ovl_end");
    step(1'b1, 1'b0, "flush_1");
    step(1'b1, 1'b0, "flush_2");

    // 01110 and a bare 110 must not match
    step(1'b0, 1'b0, "miss_0");
    step(1'b1, 1'b0, "miss_1");
    step(1'b1, 1'b0, "miss_2");
    step(1'b1, 1'b0, "miss_3");
    step(1'b0, 1'b0, "miss_4");
    step(1'b1, 1'b0, "miss_flush1");
    step(1'b1, 1'b0, "miss_flush2");
    step(1'b1, 1'b0, "miss_flush3");
    step(1'b1, 1'b0, "miss110_1");
    step(1'b1, 1'b0, "miss110_2");
    step(1'b0, 1'b0, "miss110_0");

    // Reset in S011 discards the partial match
    step(1'b0, 1'b0, "mid_0");
    step(1'b1, 1'b0, "mid_1");
    step(1'b1, 1'b0, "mid_2");
    rstn = 1'b0;
    #1;
    check("mid_reset_state", dut.r_state, IDLE);
    @(posedge clk);
    #1;
    check("mid_reset_det", {2'b00, detected}, 3'd0);
    rstn = 1'b1;
    step(1'b0, 1'b0, "mid_after_0");
    step(1'b1, 1'b0, "mid_after_1");
    step(1'b1, 1'b0, "mid_after_2");
    step(1'b0, 1'b1, "mid_after_pulse");
    step(1'b1, 1'b0, "mid_after_end");

    // Reset while in DET drops detected without a clock edge
    step(1'b1, 1'b0, "det_rst_1");
    step(1'b0, 1'b1, "det_rst_pulse");
    #2;
    rstn = 1'b0;
    #1;
    check("det_rst_async", {2'b00, detected}, 3'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Input timing: rx changes 1 ns after the edge
    step(1'b1, 1'b0, "tim_pre");
    step(1'b0, 1'b0, "tim_late_0");
    step(1'b1, 1'b0, "tim_late_1");
    step(1'b1, 1'b0, "tim_late_2");
    step(1'b0, 1'b1, "tim_late_pulse");
    step(1'b1, 1'b0, "tim_late_end");
    step(1'b1, 1'b0, "tim_flush1");
    step(1'b1, 1'b0, "tim_flush2");

    // Same pattern with rx changing exactly at the edge; each check lags one bit
    edge_step(1'b0, 1'b0, "tim_edge_idle");
    edge_step(1'b1, 1'b0, "tim_edge_0");
    edge_step(1'b1, 1'b0, "tim_edge_1");
    edge_step(1'b0, 1'b0, "tim_edge_2");
    edge_step(1'b1, 1'b1, "tim_edge_pulse");
    edge_step(1'b1, 1'b0, "tim_edge_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sequence_detector.md
SEQUENCE_DETECTOR -- requirements
Module: sequence_detector

Interface
REQ-001 Parameters: none; the pattern is the package constant, fixed at 4'b0110 (first-received bit is MSB).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous assertion, active-low.
REQ-004 rx  input  1  serial data bit, one bit sampled per rising clk edge.
REQ-005 detected  output  1  high for exactly one clk cycle when the last four sampled rx bits equal 0,1,1,0 in arrival order.

Function
REQ-006 The block SHALL be a Moore FSM with five states: IDLE (no prefix), S0 (seen 0), S01 (seen 01), S011 (seen 011), DET (seen 0110).
REQ-007 Transitions for rx=0 / rx=1 SHALL be:
- IDLE -> S0 / IDLE
- S0 -> S0 / S01
- S01 -> S0 / S011
- S011 -> DET / IDLE
- DET -> S0 / S01
REQ-008 Detection SHALL be overlapping: the trailing 0 of a detected 0110 SHALL count as the leading 0 of the next candidate, so 0110110 yields two pulses.
REQ-009 detected SHALL be driven directly from the state register (state==DET), with no combinational path from rx.
REQ-010 Latency: when the final 0 is sampled at rising edge N, detected SHALL be 1 from edge N until edge N+1.
REQ-011 Consecutive pulses SHALL be at least 3 cycles apart, which follows from REQ-007.
REQ-012 Next-state logic SHALL include a default branch returning IDLE, so any illegal or unknown encoding recovers to IDLE within one cycle.
REQ-013 rx values sampled before the first defined drive are don't-care; the state SHALL be IDLE whenever rstn is low.
REQ-014 rx changing in the same timestep as the rising edge SHALL follow standard nonblocking semantics: the value present before the edge is sampled.

Reset
REQ-015 rstn low SHALL immediately (asynchronously) force state=IDLE and detected=0, independent of clk.
REQ-016 Reset deassertion SHALL take effect on the next rising clk edge; the first rx bit is sampled at that edge.
REQ-017 Reset mid-pattern (for example in S011) SHALL discard the partial match; the full 0110 must be received again after release.
REQ-018 Reset asserted while in DET SHALL drop detected to 0 within the same timestep.

Structure
REQ-019 Package sequence_detector_pkg SHALL hold:
- the state enum typedef (IDLE, S0, S01, S011, DET), 3-bit encoding
- the constant PATTERN = 4'b0110
- the constant PATTERN_LEN = 4
REQ-020 There SHALL be no sub-module: one sequential always_ff for state, one always_comb for next state, one continuous assign for detected.

Verification
REQ-021 Hold rstn=0 for 2 cycles with random rx -> detected=0 throughout; state is IDLE at release.
REQ-022 After reset, drive 0,1,1,0 on four consecutive edges -> detected=1 for exactly the one cycle following the fourth edge, then 0.
REQ-023 Drive 0,1,1,0,1,1,0 -> two one-cycle pulses, 3 cycles apart (overlap).
REQ-024 Drive 0,1,1,1,0 and 1,1,0 -> detected never asserts.
REQ-025 Drive 0,1,1, then assert rstn for 1 cycle, release, then drive 0 -> no pulse; a following 1,1,0 -> one pulse.
REQ-026 Drive 0,1,1,0 with rx updated 1 ns after each rising edge, then repeat the sequence with rx updated exactly at the edge -> both runs pulse once with identical timing relative to the sampled bits.
